// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - character handshake between the bus-side TX register and the serializer
//
// Signals:
//   data_ready : bus side -> serializer, level, tx_data valid (asynchronous to the serializer clock)
//   tx_data    : bus side -> serializer, character, stable while data_ready=1
//   tx_busy    : serializer -> bus side, high from frame accept until the end of the last stop bit
//   tx_done    : serializer -> bus side, one-cycle pulse at the end of the last stop bit
interface uart_tx_serializer_if #(
    parameter int CHAR_W = 8
);
    logic              data_ready;
    logic [CHAR_W-1:0] tx_data;
    logic              tx_busy;
    logic              tx_done;

    modport master (
        output data_ready,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  data_ready,
        input  tx_data,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART TX back end: accepts one character and shifts out an async frame
//
// Ports:
//   clock       : bit-timing clock
//   n_reset     : asynchronous active-low reset
//   bus         : slave side of uart_tx_serializer_if (data_ready, tx_data in; tx_busy, tx_done out)
//   uart_tx_pin : serial line, idle high
//
// Parameters: DIVIDER clocks per bit (>=2), CHAR_W data bits, PARITY 0 none / 1 even / 2 odd,
// STOP_BITS 1 or 2.
module uart_tx_serializer #(
    parameter int DIVIDER   = 4096,
    parameter int CHAR_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                  clock,
    input  logic                  n_reset,
    uart_tx_serializer_if.slave   bus,
    output logic                  uart_tx_pin
);

    localparam int BAUD_W = $clog2(DIVIDER);
    localparam int CNT_W  = $clog2(CHAR_W + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVIDER - 1);
    localparam logic [BAUD_W-1:0] DONE_AT   = BAUD_W'(DIVIDER - 2);
    localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(CHAR_W - 1);
    localparam logic [CNT_W-1:0]  LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic              ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [CNT_W-1:0]    bit_q, bit_d;
    logic [CHAR_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic                sync1_q, sync1_d;
    logic                rdy_s_q, rdy_s_d;
    logic [1:0]          primed_q, primed_d;
    logic                armed_q, armed_d;
    logic                pin_q, pin_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                bit_end;
    logic [CHAR_W-1:0]   shift_next;

    assign bit_end    = (baud_q == BAUD_LAST);
    assign shift_next = shift_q >> 1;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        armed_d  = armed_q;
        pin_d    = pin_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        sync1_d  = bus.data_ready;
        rdy_s_d  = sync1_q;
        // The sync stages come out of reset holding 0, which is not a real sample of
        // data_ready. primed_q marks when rdy_s_q reflects the input, so a data_ready
        // held high through reset cannot arm a fresh transmission.
        primed_d = {primed_q[0], 1'b1};

        if (primed_q[1] && !rdy_s_q) begin
            armed_d = 1'b1;
        end

        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                pin_d  = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = '0;
                if (rdy_s_q && armed_q) begin
                    shift_d = bus.tx_data;
                    par_d   = (^bus.tx_data) ^ ODD_PAR;
                    armed_d = 1'b0;
                    state_d = START;
                    pin_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    pin_d   = shift_q[0];
                    bit_d   = '0;
                end
            end

            DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = PARITY_BIT;
                            pin_d   = par_q;
                        end else begin
                            state_d = STOP;
                            pin_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + CNT_W'(1);
                        shift_d = shift_next;
                        pin_d   = shift_next[0];
                    end
                end
            end

            PARITY_BIT: begin
                if (bit_end) begin
                    state_d = STOP;
                    pin_d   = 1'b1;
                    bit_d   = '0;
                end
            end

            STOP: begin
                pin_d = 1'b1;
                // Registered pulse: set one cycle early so it is high during the final cycle.
                if (bit_q == LAST_STOP && baud_q == DONE_AT) begin
                    done_d = 1'b1;
                end
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                pin_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            sync1_q  <= 1'b0;
            rdy_s_q  <= 1'b0;
            primed_q <= 2'b00;
            armed_q  <= 1'b0;
            pin_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            sync1_q  <= sync1_d;
            rdy_s_q  <= rdy_s_d;
            primed_q <= primed_d;
            armed_q  <= armed_d;
            pin_q    <= pin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign uart_tx_pin = pin_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer over four parameter sets
module tb_uart_tx_serializer;

    localparam int DIV = 16;
    localparam int NI  = 4;

    logic          clock;
    logic          n_reset;
    logic [NI-1:0] dr;
    logic [7:0]    td [NI];
    logic [NI-1:0] busy;
    logic [NI-1:0] done;
    logic [NI-1:0] pin;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         k;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];

    // Instance 0: no parity, 1 stop; 1: even parity; 2: odd parity; 3: no parity, 2 stops.
    function automatic int par_of(input int k);
        return (k == 1) ? 1 : (k == 2) ? 2 : 0;
    endfunction

    function automatic int stop_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_serializer_if #(.CHAR_W(8)) bus ();
        assign bus.data_ready = dr[g];
        assign bus.tx_data    = td[g];
        assign busy[g]        = bus.tx_busy;
        assign done[g]        = bus.tx_done;

        uart_tx_serializer #(
            .DIVIDER  (DIV),
            .CHAR_W   (8),
            .PARITY   ((g == 1) ? 1 : (g == 2) ? 2 : 0),
            .STOP_BITS((g == 3) ? 2 : 1)
        ) u_dut (
            .clock      (clock),
            .n_reset    (n_reset),
            .bus        (bus.slave),
            .uart_tx_pin(pin[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a character, record the expected frame and confirm the 3-edge accept latency.
    task automatic send(input int k, input logic [7:0] data, input bit hold);
        exp_t e;
        int   lat;
        @(negedge clock);
        td[k] = data;
        dr[k] = 1'b1;
        e.k = k;
        e.d = data;
        sb.push_back(e);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!busy[k] && lat < 20);
        check($sformatf("accept_lat k%0d", k), lat, 3);
        if (!hold) begin
            dr[k] = 1'b0;
            td[k] = ~data;
        end
    endtask

    // Capture one frame cycle by cycle and compare it with the oldest scoreboard entry.
    task automatic rx_frame(input int k);
        int   t;
        int   n;
        int   dcnt;
        int   ones;
        int   nb;
        logic last_done;
        logic smp[$];
        logic eb[$];
        exp_t e;
        t = 0;
        while (!busy[k] && t < 400) begin
            @(negedge clock);
            t++;
        end
        check($sformatf("frame_start k%0d", k), busy[k], 1'b1);
        n = 0;
        dcnt = 0;
        last_done = 1'b0;
        while (busy[k] && n < 400) begin
            smp.push_back(pin[k]);
            dcnt += int'(done[k]);
            last_done = done[k];
            n++;
            @(negedge clock);
        end
        check($sformatf("done_after k%0d", k), done[k], 1'b0);
        check($sformatf("sb_pending k%0d", k), (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("sb_inst", k, e.k);
        eb.push_back(1'b0);
        for (int i = 0; i < 8; i++) eb.push_back(e.d[i]);
        if (par_of(k) == 1) eb.push_back(^e.d);
        if (par_of(k) == 2) eb.push_back(~^e.d);
        for (int i = 0; i < stop_of(k); i++) eb.push_back(1'b1);
        nb = eb.size();
        check($sformatf("frame_len k%0d d%02h", k, e.d), n, nb * DIV);
        check($sformatf("done_cnt k%0d", k), dcnt, 1);
        check($sformatf("done_last k%0d", k), last_done, 1'b1);
        for (int i = 0; i < nb; i++) begin
            ones = 0;
            for (int j = 0; j < DIV; j++) begin
                if (i * DIV + j < n) ones += int'(smp[i * DIV + j]);
            end
            check($sformatf("k%0d d%02h slot%0d", k, e.d, i), ones, eb[i] ? DIV : 0);
        end
    endtask

    initial begin
        int cnt;
        int lows;
        int gap;
        n_reset = 1'b0;
        dr      = '0;
        for (int i = 0; i < NI; i++) td[i] = 8'h00;

        repeat (3) @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_pin k%0d", k), pin[k], 1'b1);
            check($sformatf("rst_busy k%0d", k), busy[k], 1'b0);
            check($sformatf("rst_done k%0d", k), done[k], 1'b0);
        end
        n_reset = 1'b1;
        repeat (5) @(negedge clock);

        // Basic frame; tx_data changes after accept and must not affect it.
        send(0, 8'hA5, 1'b0);
        rx_frame(0);

        // Even / odd parity and two stop bits.
        send(1, 8'h07, 1'b0);
        rx_frame(1);
        send(2, 8'h07, 1'b0);
        rx_frame(2);
        send(3, 8'h00, 1'b0);
        rx_frame(3);

        // data_ready held through three frame times sends exactly one frame.
        send(0, 8'hE1, 1'b1);
        rx_frame(0);
        cnt = 0;
        repeat (2 * 10 * DIV) begin
            @(negedge clock);
            cnt += int'(busy[0]);
        end
        check("hold_no_refire", cnt, 0);
        dr[0] = 1'b0;
        repeat (5) @(negedge clock);
        send(0, 8'h96, 1'b0);
        rx_frame(0);

        // Back-to-back: second request arrives mid-frame.
        send(0, 8'h55, 1'b0);
        fork
            rx_frame(0);
            begin
                repeat (50) @(negedge clock);
                td[0] = 8'h3C;
                dr[0] = 1'b1;
                begin
                    exp_t e2;
                    e2.k = 0;
                    e2.d = 8'h3C;
                    sb.push_back(e2);
                end
            end
        join
        gap = 0;
        while (!busy[0] && gap < 20) begin
            gap++;
            @(negedge clock);
        end
        check("b2b_gap", gap, 1);
        dr[0] = 1'b0;
        rx_frame(0);

        // Reset in the middle of data bit 3, with data_ready re-asserted and held.
        repeat (3) @(negedge clock);
        send(0, 8'h00, 1'b0);
        repeat (70) @(negedge clock);
        check("pre_rst_pin", pin[0], 1'b0);
        check("pre_rst_busy", busy[0], 1'b1);
        td[0] = 8'h5A;
        dr[0] = 1'b1;
        #2;
        n_reset = 1'b0;
        #1;
        check("async_rst_pin", pin[0], 1'b1);
        check("async_rst_busy", busy[0], 1'b0);
        check("async_rst_done", done[0], 1'b0);
        sb.delete();
        repeat (2) @(negedge clock);
        n_reset = 1'b1;
        cnt = 0;
        lows = 0;
        repeat (100) begin
            @(negedge clock);
            cnt += int'(busy[0]);
            lows += int'(!pin[0]);
        end
        check("post_rst_no_busy", cnt, 0);
        check("post_rst_line_high", lows, 0);
        dr[0] = 1'b0;
        repeat (5) @(negedge clock);
        send(0, 8'h5A, 1'b0);
        rx_frame(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
